// File: rtl/exe_stage.sv
// Execute stage: latches decoded operands, evaluates a one-hot ALU (including
// a combinational multiplier and a 32-step restoring divider that stalls the
// stage), issues data-SRAM requests for ld.w/st.w, and exposes the write-back
// tag and live result to decode for hazard detection and forwarding.
module exe_stage (
    input  logic        clk,
    input  logic        resetn,
    input  logic        id_to_exe_valid,
    output logic        exe_allowin,
    input  logic [31:0] id_pc,
    input  logic [82:0] id_alu_data_zip,
    input  logic [5:0]  id_rf_zip,
    input  logic        id_res_from_mem,
    input  logic        id_mem_we,
    input  logic [31:0] id_rkd_value,
    input  logic        mem_allowin,
    output logic        exe_to_mem_valid,
    output logic [31:0] exe_pc,
    output logic [31:0] exe_alu_result,
    output logic        exe_res_from_mem,
    output logic [5:0]  exe_rf_zip,
    output logic        data_sram_en,
    output logic [3:0]  data_sram_we,
    output logic [31:0] data_sram_addr,
    output logic [31:0] data_sram_wdata
);

    typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_t;

    logic        r_valid;
    logic [31:0] r_pc;
    logic [18:0] r_alu_op;
    logic [31:0] r_src1;
    logic [31:0] r_src2;
    logic        r_rf_we;
    logic [4:0]  r_rf_waddr;
    logic        r_res_from_mem;
    logic        r_mem_we;
    logic [31:0] r_rkd_value;

    div_state_t  r_div_state;
    logic [4:0]  r_div_cnt;
    logic [63:0] r_div_rq;      // {partial remainder, dividend/quotient}
    logic [31:0] r_div_dsr;
    logic        r_div_qneg;
    logic        r_div_rneg;
    logic        r_div_zero;

    logic        w_div_op;
    logic        w_ready_go;
    logic        w_div_signed;
    logic        w_sgn1;
    logic        w_sgn2;
    logic [31:0] w_abs1;
    logic [31:0] w_abs2;
    logic [63:0] w_div_shift;
    logic [32:0] w_div_diff;
    logic [63:0] w_div_step;
    logic [31:0] w_quot;
    logic [31:0] w_rem;
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic [31:0] w_sra;
    logic [31:0] w_result;

    // Handshake: only an unfinished divide holds the instruction back.
    assign w_div_op         = r_valid & (|r_alu_op[18:15]);
    assign w_ready_go       = ~w_div_op | (r_div_state == DIV_DONE);
    assign exe_allowin      = ~r_valid | (w_ready_go & mem_allowin);
    assign exe_to_mem_valid = r_valid & w_ready_go;

    // Stage valid bit.
    always_ff @(posedge clk) begin
        if (!resetn)          r_valid <= 1'b0;
        else if (exe_allowin) r_valid <= id_to_exe_valid;
    end

    // Payload registers capture only on an actual transfer from decode.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_pc           <= '0;
            r_alu_op       <= '0;
            r_src1         <= '0;
            r_src2         <= '0;
            r_rf_we        <= 1'b0;
            r_rf_waddr     <= '0;
            r_res_from_mem <= 1'b0;
            r_mem_we       <= 1'b0;
            r_rkd_value    <= '0;
        end else if (id_to_exe_valid && exe_allowin) begin
            r_pc           <= id_pc;
            r_alu_op       <= id_alu_data_zip[82:64];
            r_src1         <= id_alu_data_zip[63:32];
            r_src2         <= id_alu_data_zip[31:0];
            r_rf_we        <= id_rf_zip[5];
            r_rf_waddr     <= id_rf_zip[4:0];
            r_res_from_mem <= id_res_from_mem;
            r_mem_we       <= id_mem_we;
            r_rkd_value    <= id_rkd_value;
        end
    end

    // Divider operand conditioning: signed ops work on magnitudes.
    assign w_div_signed = r_alu_op[15] | r_alu_op[17];
    assign w_sgn1       = w_div_signed & r_src1[31];
    assign w_sgn2       = w_div_signed & r_src2[31];
    assign w_abs1       = w_sgn1 ? (~r_src1 + 32'd1) : r_src1;
    assign w_abs2       = w_sgn2 ? (~r_src2 + 32'd1) : r_src2;

    // One restoring step: shift left, subtract divisor if it fits.
    assign w_div_shift = {r_div_rq[62:0], 1'b0};
    assign w_div_diff  = {1'b0, w_div_shift[63:32]} - {1'b0, r_div_dsr};
    assign w_div_step  = w_div_diff[32] ? w_div_shift
                                        : {w_div_diff[31:0], w_div_shift[31:1], 1'b1};

    // Divider FSM: capture in IDLE, 32 steps in BUSY, hold in DONE until handed off.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_div_state <= DIV_IDLE;
            r_div_cnt   <= '0;
            r_div_rq    <= '0;
            r_div_dsr   <= '0;
            r_div_qneg  <= 1'b0;
            r_div_rneg  <= 1'b0;
            r_div_zero  <= 1'b0;
        end else begin
            case (r_div_state)
                DIV_IDLE: if (w_div_op) begin
                    r_div_rq    <= {32'd0, w_abs1};
                    r_div_dsr   <= w_abs2;
                    r_div_qneg  <= w_sgn1 ^ w_sgn2;
                    r_div_rneg  <= w_sgn1;
                    r_div_zero  <= (r_src2 == 32'd0);
                    r_div_cnt   <= '0;
                    r_div_state <= DIV_BUSY;
                end
                DIV_BUSY: begin
                    r_div_rq  <= w_div_step;
                    r_div_cnt <= r_div_cnt + 5'd1;
                    if (r_div_cnt == 5'd31) r_div_state <= DIV_DONE;
                end
                DIV_DONE: if (exe_to_mem_valid && mem_allowin) r_div_state <= DIV_IDLE;
                default:  r_div_state <= DIV_IDLE;
            endcase
        end
    end

    // Sign fix-up; divide by zero bypasses it and returns all-ones / dividend.
    assign w_quot = r_div_zero ? 32'hFFFF_FFFF
                  : (r_div_qneg ? (~r_div_rq[31:0] + 32'd1) : r_div_rq[31:0]);
    assign w_rem  = r_div_zero ? r_src1
                  : (r_div_rneg ? (~r_div_rq[63:32] + 32'd1) : r_div_rq[63:32]);

    // Full 64-bit products; sign-extended operands give the signed product.
    assign w_prod_s = {{32{r_src1[31]}}, r_src1} * {{32{r_src2[31]}}, r_src2};
    assign w_prod_u = {32'd0, r_src1} * {32'd0, r_src2};
    assign w_sra    = $signed(r_src1) >>> r_src2[4:0];

    // One-hot result select; an all-zero op falls through to 0.
    always_comb begin
        w_result = '0;
        w_result = w_result | ({32{r_alu_op[0]}}  & (r_src1 + r_src2));
        w_result = w_result | ({32{r_alu_op[1]}}  & (r_src1 - r_src2));
        w_result = w_result | ({32{r_alu_op[2]}}  & {31'd0, $signed(r_src1) < $signed(r_src2)});
        w_result = w_result | ({32{r_alu_op[3]}}  & {31'd0, r_src1 < r_src2});
        w_result = w_result | ({32{r_alu_op[4]}}  & (r_src1 & r_src2));
        w_result = w_result | ({32{r_alu_op[5]}}  & ~(r_src1 | r_src2));
        w_result = w_result | ({32{r_alu_op[6]}}  & (r_src1 | r_src2));
        w_result = w_result | ({32{r_alu_op[7]}}  & (r_src1 ^ r_src2));
        w_result = w_result | ({32{r_alu_op[8]}}  & (r_src1 << r_src2[4:0]));
        w_result = w_result | ({32{r_alu_op[9]}}  & (r_src1 >> r_src2[4:0]));
        w_result = w_result | ({32{r_alu_op[10]}} & w_sra);
        w_result = w_result | ({32{r_alu_op[11]}} & r_src2);
        w_result = w_result | ({32{r_alu_op[12]}} & w_prod_u[31:0]);
        w_result = w_result | ({32{r_alu_op[13]}} & w_prod_s[63:32]);
        w_result = w_result | ({32{r_alu_op[14]}} & w_prod_u[63:32]);
        w_result = w_result | ({32{r_alu_op[15] | r_alu_op[16]}} & w_quot);
        w_result = w_result | ({32{r_alu_op[17] | r_alu_op[18]}} & w_rem);
    end

    assign exe_pc           = r_pc;
    assign exe_alu_result   = w_result;
    assign exe_res_from_mem = r_valid & r_res_from_mem;
    assign exe_rf_zip       = {r_valid & r_rf_we, r_rf_waddr};

    // Requests fire only on the cycle the instruction moves on, so each issues once.
    assign data_sram_en    = r_valid & (r_res_from_mem | r_mem_we) & mem_allowin;
    assign data_sram_we    = {4{r_valid & r_mem_we & mem_allowin}};
    assign data_sram_addr  = w_result;
    assign data_sram_wdata = r_rkd_value;

endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage: a table of ALU/mul/div vectors plus hand
// sequences for store stalls, DONE hold, and reset in the middle of a divide.
module tb_exe_stage;

    logic        clk = 1'b0;
    logic        resetn;
    logic        id_to_exe_valid;
    logic        exe_allowin;
    logic [31:0] id_pc;
    logic [82:0] id_alu_data_zip;
    logic [5:0]  id_rf_zip;
    logic        id_res_from_mem;
    logic        id_mem_we;
    logic [31:0] id_rkd_value;
    logic        mem_allowin;
    logic        exe_to_mem_valid;
    logic [31:0] exe_pc;
    logic [31:0] exe_alu_result;
    logic        exe_res_from_mem;
    logic [5:0]  exe_rf_zip;
    logic        data_sram_en;
    logic [3:0]  data_sram_we;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;

    exe_stage dut (
        .clk(clk), .resetn(resetn),
        .id_to_exe_valid(id_to_exe_valid), .exe_allowin(exe_allowin),
        .id_pc(id_pc), .id_alu_data_zip(id_alu_data_zip), .id_rf_zip(id_rf_zip),
        .id_res_from_mem(id_res_from_mem), .id_mem_we(id_mem_we),
        .id_rkd_value(id_rkd_value), .mem_allowin(mem_allowin),
        .exe_to_mem_valid(exe_to_mem_valid), .exe_pc(exe_pc),
        .exe_alu_result(exe_alu_result), .exe_res_from_mem(exe_res_from_mem),
        .exe_rf_zip(exe_rf_zip), .data_sram_en(data_sram_en),
        .data_sram_we(data_sram_we), .data_sram_addr(data_sram_addr),
        .data_sram_wdata(data_sram_wdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          op;    // one-hot bit index; 31 = no op bit set
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    localparam int NV = 28;
    vec_t tv [NV];
    int   nvec = 0;
    int   nerr = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic issue(input logic [18:0] opv, input logic [31:0] a, input logic [31:0] b,
                         input logic [5:0] rf, input logic [31:0] pc);
        id_alu_data_zip = {opv, a, b};
        id_rf_zip       = rf;
        id_pc           = pc;
        id_to_exe_valid = 1'b1;
        @(posedge clk); #1;
        id_to_exe_valid = 1'b0;
    endtask

    // Issue one table entry, wait for it to become ready, check value and timing.
    task automatic run_vec(input int idx);
        logic [18:0] opv;
        logic        isdiv;
        logic [5:0]  rf;
        int          lat;
        int          low;
        opv   = (tv[idx].op > 18) ? 19'd0 : (19'd1 << tv[idx].op);
        isdiv = (tv[idx].op >= 15) && (tv[idx].op <= 18);
        rf    = {1'b1, 5'(idx)};
        issue(opv, tv[idx].a, tv[idx].b, rf, 32'h1C00_0000 + 32'(idx * 4));
        lat = 0;
        low = 0;
        while (!exe_to_mem_valid && lat < 100) begin
            if (!exe_allowin) low++;
            @(posedge clk); #1;
            lat++;
        end
        chk($sformatf("v%0d result", idx), exe_alu_result, tv[idx].exp);
        chk($sformatf("v%0d latency", idx), 32'(lat), isdiv ? 32'd33 : 32'd0);
        chk($sformatf("v%0d allowin_low", idx), 32'(low), isdiv ? 32'd33 : 32'd0);
        chk($sformatf("v%0d rf_zip", idx), {26'd0, exe_rf_zip}, {26'd0, rf});
        chk($sformatf("v%0d pc", idx), exe_pc, 32'h1C00_0000 + 32'(idx * 4));
    endtask

    initial begin
        tv[0]  = '{0,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000};  // add
        tv[1]  = '{1,  32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE};  // sub
        tv[2]  = '{2,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001};  // slt
        tv[3]  = '{3,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};  // sltu
        tv[4]  = '{4,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000};  // and
        tv[5]  = '{5,  32'h0F0F_0000, 32'h0000_00FF, 32'hF0F0_FF00};  // nor
        tv[6]  = '{6,  32'h1234_0000, 32'h0000_5678, 32'h1234_5678};  // or
        tv[7]  = '{7,  32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F};  // xor
        tv[8]  = '{8,  32'h0000_0001, 32'h0000_003F, 32'h8000_0000};  // sll by 31
        tv[9]  = '{9,  32'h8000_0000, 32'h0000_0004, 32'h0800_0000};  // srl
        tv[10] = '{10, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000};  // sra
        tv[11] = '{11, 32'h1111_1111, 32'hABCD_E000, 32'hABCD_E000};  // lui
        tv[12] = '{12, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000};  // mul.w
        tv[13] = '{13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};  // mulh.w
        tv[14] = '{14, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};  // mulh.wu
        tv[15] = '{13, 32'h8000_0000, 32'h0000_0002, 32'hFFFF_FFFF};  // mulh.w -2^32
        tv[16] = '{31, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000};  // no op
        tv[17] = '{15, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD};  // div.w -7/2
        tv[18] = '{17, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF};  // mod.w -7/2
        tv[19] = '{16, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF};  // div.wu 5/0
        tv[20] = '{18, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005};  // mod.wu 5/0
        tv[21] = '{15, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};  // div.w overflow
        tv[22] = '{17, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000};  // mod.w overflow
        tv[23] = '{16, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E};  // div.wu 100/7
        tv[24] = '{18, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002};  // mod.wu 100/7
        tv[25] = '{15, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD};  // div.w 7/-2
        tv[26] = '{17, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001};  // mod.w 7/-2
        tv[27] = '{17, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB};  // mod.w -5/0

        resetn          = 1'b0;
        id_to_exe_valid = 1'b0;
        id_pc           = '0;
        id_alu_data_zip = '0;
        id_rf_zip       = '0;
        id_res_from_mem = 1'b0;
        id_mem_we       = 1'b0;
        id_rkd_value    = '0;
        mem_allowin     = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        chk("rst exe_to_mem_valid", {31'd0, exe_to_mem_valid}, 32'd0);
        chk("rst exe_allowin", {31'd0, exe_allowin}, 32'd1);
        chk("rst sram_en", {31'd0, data_sram_en}, 32'd0);
        chk("rst sram_we", {28'd0, data_sram_we}, 32'd0);
        chk("rst exe_pc", exe_pc, 32'd0);
        chk("rst alu_result", exe_alu_result, 32'd0);
        chk("rst rf_zip", {26'd0, exe_rf_zip}, 32'd0);
        resetn = 1'b1;

        // Table: back-to-back issue, including consecutive divides
        for (int i = 0; i < NV; i++) run_vec(i);
        @(posedge clk); #1;
        chk("drain valid", {31'd0, exe_to_mem_valid}, 32'd0);

        // st.w held by mem_allowin low for three cycles, then one write pulse
        mem_allowin  = 1'b0;
        id_mem_we    = 1'b1;
        id_rkd_value = 32'hDEAD_BEEF;
        issue(19'd1, 32'h0000_1000, 32'h0000_0024, 6'd0, 32'h1C00_1000);
        id_mem_we    = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("st we stalled", {28'd0, data_sram_we}, 32'd0);
            chk("st en stalled", {31'd0, data_sram_en}, 32'd0);
            chk("st valid stalled", {31'd0, exe_to_mem_valid}, 32'd1);
            @(posedge clk); #1;
        end
        mem_allowin = 1'b1;
        #1;
        chk("st we", {28'd0, data_sram_we}, 32'hF);
        chk("st en", {31'd0, data_sram_en}, 32'd1);
        chk("st addr", data_sram_addr, 32'h0000_1024);
        chk("st wdata", data_sram_wdata, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        chk("st we after", {28'd0, data_sram_we}, 32'd0);

        // Divide finishing while memory stage is blocked: result held in DONE
        begin
            int lat;
            mem_allowin = 1'b0;
            issue(19'd1 << 16, 32'd100, 32'd7, 6'h21, 32'h1C00_2000);
            lat = 0;
            while (!exe_to_mem_valid && lat < 100) begin
                @(posedge clk); #1;
                lat++;
            end
            chk("hold latency", 32'(lat), 32'd33);
            for (int k = 0; k < 3; k++) begin
                @(posedge clk); #1;
                chk("hold valid", {31'd0, exe_to_mem_valid}, 32'd1);
                chk("hold result", exe_alu_result, 32'h0000_000E);
                chk("hold allowin", {31'd0, exe_allowin}, 32'd0);
            end
            mem_allowin = 1'b1;
            @(posedge clk); #1;
            chk("hold released", {31'd0, exe_to_mem_valid}, 32'd0);
        end

        // Reset at E10 of a divide, then normal operation resumes
        issue(19'd1 << 15, 32'hFFFF_FFF9, 32'd2, 6'h22, 32'h1C00_3000);
        repeat (10) @(posedge clk);
        #1;
        chk("mid-div allowin", {31'd0, exe_allowin}, 32'd0);
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        chk("post-rst valid", {31'd0, exe_to_mem_valid}, 32'd0);
        chk("post-rst allowin", {31'd0, exe_allowin}, 32'd1);
        chk("post-rst rf_zip", {26'd0, exe_rf_zip}, 32'd0);
        run_vec(0);
        run_vec(17);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
